// File: rtl/pet_pkg.sv
// Shared opcodes, mood codes, scan FSM state and mood encoding helper for pet_stat_bank.
package pet_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [1:0] MOOD_HAPPY    = 2'b00;
  localparam logic [1:0] MOOD_OK       = 2'b01;
  localparam logic [1:0] MOOD_SAD      = 2'b10;
  localparam logic [1:0] MOOD_CRITICAL = 2'b11;

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  function automatic logic [1:0] mood_of(input logic [4:0] n_low, input logic all_zero);
    if (all_zero)         return MOOD_CRITICAL;
    else if (n_low == '0) return MOOD_HAPPY;
    else if (n_low < 5'd3) return MOOD_OK;
    else                  return MOOD_SAD;
  endfunction

endpackage

// File: rtl/pet_tick_gen.sv
// Decay tick prescaler: counts 0..TICK_DIV-1, tick is high while the count sits at TICK_DIV-1.
module pet_tick_gen #(
  parameter int unsigned TICK_DIV = 10_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int unsigned   CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)           r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + CW'(1);
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/pet_stat_bank.sv
// Bank of saturating pet stats with command handshake and per-tick random decay scan.
// Optional macro PET_DEATH_EN adds a dead latch after 8 ticks with every stat at zero.
module pet_stat_bank
  import pet_pkg::*;
#(
  parameter int unsigned NUM_STATS = 6,
  parameter int unsigned STAT_W    = 4,
  parameter int unsigned TICK_DIV  = 10_000_000,
  parameter logic [31:0] INIT_VAL  = 32'hF,
  parameter int unsigned LOW_THR   = 4,
  parameter int unsigned IDX_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    rand_in,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [IDX_W-1:0]              cmd_idx,
  input  logic [STAT_W-1:0]             cmd_val,
  output logic                          cmd_err,
  output logic [NUM_STATS*STAT_W-1:0]   stats_flat,
  output logic [NUM_STATS-1:0]          low_flags,
  output logic [1:0]                    mood,
  output logic                          tick,
  output logic                          overrun
);

  localparam int unsigned          SI_W      = 4;
  localparam logic [STAT_W-1:0]    INIT_S    = INIT_VAL[STAT_W-1:0];
  localparam logic [STAT_W:0]      LOW_T     = (STAT_W+1)'(LOW_THR);
  localparam logic [NUM_STATS-1:0] INIT_LOW  = ({1'b0, INIT_S} < LOW_T) ? '1 : '0;
  localparam logic [1:0]           INIT_MOOD = mood_of(INIT_LOW[0] ? 5'(NUM_STATS) : 5'd0,
                                                       INIT_S == '0);

  state_t               r_state;
  logic [SI_W-1:0]      r_idx;
  logic [7:0]           r_rsnap;
  logic                 r_pending;
  logic                 r_overrun;
  logic                 r_cmd_err;
  logic [STAT_W-1:0]    r_stats     [NUM_STATS];
  logic [STAT_W-1:0]    w_stats_nxt [NUM_STATS];
  logic [NUM_STATS-1:0] r_low;
  logic [NUM_STATS-1:0] w_low;
  logic [1:0]           r_mood;
  logic [4:0]           w_nlow;
  logic                 w_all_zero;
  logic                 w_tick;
  logic                 w_accept;
  logic                 w_idx_bad;
  logic                 w_dead;

  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                input logic [STAT_W-1:0] b);
    logic [STAT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[STAT_W] ? '1 : s[STAT_W-1:0];
  endfunction

  pet_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .o_tick  (w_tick)
  );

`ifdef PET_DEATH_EN
  logic [3:0] r_zero_ticks;
  logic       r_dead;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero_ticks <= '0;
      r_dead       <= 1'b0;
    end else begin
      if (!w_all_zero)                        r_zero_ticks <= '0;
      else if (w_tick && r_zero_ticks != 4'd8) r_zero_ticks <= r_zero_ticks + 4'd1;
      if (r_zero_ticks == 4'd8)               r_dead <= 1'b1;
    end
  end

  assign w_dead = r_dead;
`else
  assign w_dead = 1'b0;
`endif

  assign cmd_ready = (r_state == ST_IDLE) && !w_dead;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_idx_bad = 32'(cmd_idx) >= NUM_STATS;

  // Commands only land in IDLE and decay only in SCAN, so one next-state path covers both.
  always_comb begin
    for (int unsigned i = 0; i < NUM_STATS; i++) begin
      w_stats_nxt[i] = r_stats[i];
      if (w_accept && !w_idx_bad && cmd_idx == IDX_W'(i)) begin
        case (cmd_op)
          OP_ADD:  w_stats_nxt[i] = sat_add(r_stats[i], cmd_val);
          OP_SUB:  w_stats_nxt[i] = (r_stats[i] > cmd_val) ? r_stats[i] - cmd_val : '0;
          OP_SET:  w_stats_nxt[i] = cmd_val;
          default: w_stats_nxt[i] = r_stats[i];
        endcase
      end else if (r_state == ST_SCAN && r_idx == SI_W'(i) && r_rsnap[i % 8]
                   && r_stats[i] != '0) begin
        w_stats_nxt[i] = r_stats[i] - STAT_W'(1);
      end
    end
  end

  always_comb begin
    w_low      = '0;
    w_nlow     = '0;
    w_all_zero = 1'b1;
    for (int unsigned i = 0; i < NUM_STATS; i++) begin
      w_low[i] = ({1'b0, r_stats[i]} < LOW_T);
      if (w_low[i])          w_nlow = w_nlow + 5'd1;
      if (r_stats[i] != '0)  w_all_zero = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_rsnap   <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_cmd_err <= 1'b0;
      r_stats   <= '{default: INIT_S};
      r_low     <= INIT_LOW;
      r_mood    <= INIT_MOOD;
    end else begin
      r_stats   <= w_stats_nxt;
      r_low     <= w_low;
      r_mood    <= w_dead ? MOOD_CRITICAL : mood_of(w_nlow, w_all_zero);
      r_cmd_err <= w_accept && w_idx_bad;
      case (r_state)
        ST_IDLE: begin
          if ((w_tick || r_pending) && !w_dead) begin
            r_rsnap   <= rand_in;
            r_pending <= 1'b0;
            r_idx     <= '0;
            r_state   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // One tick may queue behind a scan; a second one is dropped and flagged.
          if (w_tick) begin
            if (r_pending) r_overrun <= 1'b1;
            else           r_pending <= 1'b1;
          end
          if (r_idx == SI_W'(NUM_STATS - 1)) r_state <= ST_IDLE;
          else                               r_idx   <= r_idx + SI_W'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stats_flat = '0;
    for (int unsigned i = 0; i < NUM_STATS; i++)
      stats_flat[i*STAT_W +: STAT_W] = r_stats[i];
  end

  assign low_flags = r_low;
  assign mood      = r_mood;
  assign tick      = w_tick;
  assign overrun   = r_overrun;
  assign cmd_err   = r_cmd_err;

endmodule

// File: tb/tb_pet_stat_bank.sv
// Directed bench for pet_stat_bank: default-divider bank for commands, TICK_DIV=4 for decay,
// TICK_DIV=3 for pending/overrun.
module tb_pet_stat_bank;
  import pet_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstd_n, rst4_n, rst3_n;
  logic [7:0]  rand_in;
  logic        vd, v4, v3;
  logic [1:0]  op;
  logic [3:0]  idx, val;

  logic        rd, r4, r3, errd, err4, err3, tkd, tk4, tk3, ovd, ov4, ov3;
  logic [23:0] sd, s4, s3;
  logic [5:0]  ld, l4, l3;
  logic [1:0]  md, m4, m3;

  int tests = 0;
  int fails = 0;
  int n;

  pet_stat_bank dut_d (
    .clk(clk), .rst_n(rstd_n), .rand_in(rand_in), .cmd_valid(vd), .cmd_ready(rd),
    .cmd_op(op), .cmd_idx(idx), .cmd_val(val), .cmd_err(errd), .stats_flat(sd),
    .low_flags(ld), .mood(md), .tick(tkd), .overrun(ovd));

  pet_stat_bank #(.TICK_DIV(4)) dut_4 (
    .clk(clk), .rst_n(rst4_n), .rand_in(rand_in), .cmd_valid(v4), .cmd_ready(r4),
    .cmd_op(op), .cmd_idx(idx), .cmd_val(val), .cmd_err(err4), .stats_flat(s4),
    .low_flags(l4), .mood(m4), .tick(tk4), .overrun(ov4));

  pet_stat_bank #(.NUM_STATS(6), .TICK_DIV(3)) dut_3 (
    .clk(clk), .rst_n(rst3_n), .rand_in(rand_in), .cmd_valid(v3), .cmd_ready(r3),
    .cmd_op(op), .cmd_idx(idx), .cmd_val(val), .cmd_err(err3), .stats_flat(s3),
    .low_flags(l3), .mood(m3), .tick(tk3), .overrun(ov3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit to4, input logic [1:0] o, input logic [3:0] i,
                      input logic [3:0] v, input string tag);
    int k;
    k   = 0;
    op  = o;
    idx = i;
    val = v;
    if (to4) v4 = 1'b1; else vd = 1'b1;
    while (!(to4 ? r4 : rd) && k < 50) begin
      step();
      k++;
    end
    check(tag, 32'(k < 50), 32'd1);
    step();
    vd = 1'b0;
    v4 = 1'b0;
  endtask

  task automatic wait_tick(input bit on3, input string tag);
    int k;
    k = 0;
    while (!(on3 ? tk3 : tk4) && k < 40) begin
      step();
      k++;
    end
    check(tag, 32'(on3 ? tk3 : tk4), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstd_n = 1'b0; rst4_n = 1'b0; rst3_n = 1'b0;
    vd = 1'b0; v4 = 1'b0; v3 = 1'b0;
    op = OP_NOP; idx = '0; val = '0;
    rand_in = 8'h05;
    step(); step();
    rstd_n = 1'b1;
    step();

    check("d_reset_stats", sd, 24'hFFFFFF);
    check("d_reset_low", ld, 6'h00);
    check("d_reset_mood", md, MOOD_HAPPY);
    check("d_reset_ready", rd, 1'b1);
    check("d_reset_overrun", ovd, 1'b0);
    check("d_reset_err", errd, 1'b0);
    check("d_reset_tick", tkd, 1'b0);

    send(0, OP_SET, 4'd1, 4'hE, "d_set1_hs");
    check("d_set1", sd, 24'hFFFFEF);
    send(0, OP_ADD, 4'd1, 4'h5, "d_add1_hs");
    check("d_add_sat", sd, 24'hFFFFFF);
    send(0, OP_SET, 4'd3, 4'h3, "d_set3_hs");
    check("d_set3", sd, 24'hFF3FFF);
    send(0, OP_SUB, 4'd3, 4'h9, "d_sub3_hs");
    check("d_sub_sat", sd, 24'hFF0FFF);
    step();
    check("d_low_one", ld, 6'h08);
    check("d_mood_ok", md, MOOD_OK);

    send(0, OP_ADD, 4'd7, 4'h1, "d_bad_hs");
    check("d_err_pulse", errd, 1'b1);
    check("d_bad_nochange", sd, 24'hFF0FFF);
    step();
    check("d_err_clear", errd, 1'b0);
    send(0, OP_NOP, 4'd2, 4'h5, "d_nop_hs");
    check("d_nop", sd, 24'hFF0FFF);
    check("d_nop_err", errd, 1'b0);

    send(0, OP_SET, 4'd4, 4'h4, "d_set4a_hs");
    step();
    check("d_thr_equal", ld, 6'h08);
    send(0, OP_SET, 4'd4, 4'h3, "d_set4b_hs");
    step();
    check("d_thr_below", ld, 6'h18);
    check("d_mood_ok2", md, MOOD_OK);
    send(0, OP_SET, 4'd5, 4'h0, "d_set5_hs");
    step();
    check("d_low_three", ld, 6'h38);
    check("d_mood_sad", md, MOOD_SAD);
    send(0, OP_SET, 4'd0, 4'h0, "d_z0_hs");
    send(0, OP_SET, 4'd1, 4'h0, "d_z1_hs");
    send(0, OP_SET, 4'd2, 4'h0, "d_z2_hs");
    send(0, OP_SET, 4'd4, 4'h0, "d_z4_hs");
    check("d_all_zero", sd, 24'h000000);
    check("d_mood_lag", md, MOOD_SAD);
    step();
    check("d_mood_crit", md, MOOD_CRITICAL);
    check("d_low_all", ld, 6'h3F);

    rst4_n = 1'b1;
    wait_tick(0, "t4_first_tick");
    n = 0;
    step();
    while (!r4 && n < 20) begin
      n++;
      step();
    end
    check("t4_scan_len", n, 6);
    check("t4_first_scan", s4, 24'hFFFEFE);
    n = 0;
    while (!(s4[3:0] == 4'h0 && s4[11:8] == 4'h0) && n < 600) begin
      step();
      n++;
    end
    check("t4_decay_zero", s4, 24'hFFF0F0);
    repeat (50) step();
    check("t4_decay_hold", s4, 24'hFFF0F0);
    check("t4_low", l4, 6'h05);
    check("t4_mood_ok", m4, MOOD_OK);

    for (int i = 0; i < 6; i++) send(1, OP_SET, 4'(i), 4'h0, "t4_zero_hs");
    check("t4_err", err4, 1'b0);
    step();
    check("t4_zero_stats", s4, 24'h000000);
    check("t4_mood_crit", m4, MOOD_CRITICAL);
    repeat (80) step();
`ifdef PET_DEATH_EN
    op = OP_ADD; idx = 4'd1; val = 4'h3; v4 = 1'b1;
    repeat (20) step();
    v4 = 1'b0;
    check("t4_dead_ready", r4, 1'b0);
    check("t4_dead_stats", s4, 24'h000000);
    check("t4_dead_mood", m4, MOOD_CRITICAL);
`else
    send(1, OP_ADD, 4'd1, 4'h3, "t4_alive_hs");
    check("t4_alive_add", s4, 24'h000030);
    step();
    check("t4_alive_mood", m4, MOOD_SAD);
`endif

    rst4_n = 1'b0;
    step();
    rst4_n = 1'b1;
    wait_tick(0, "t4_tick2");
    step(); step(); step();
    check("t4_midscan_ready", r4, 1'b0);
    check("t4_midscan_stats", s4, 24'hFFFFFE);
    #1 rst4_n = 1'b0;
    #1;
    check("t4_async_stats", s4, 24'hFFFFFF);
    check("t4_async_ready", r4, 1'b1);
    check("t4_async_mood", m4, MOOD_HAPPY);
    step();
    rst4_n = 1'b1;
    step();
    check("t4_release_ready", r4, 1'b1);
    check("t4_release_stats", s4, 24'hFFFFFF);

    rst3_n = 1'b1;
    check("t3_reset_low", l3, 6'h00);
    check("t3_reset_mood", m3, MOOD_HAPPY);
    wait_tick(1, "t3_tick");
    step();
    check("t3_tick_pulse", tk3, 1'b0);
    check("t3_scan_ready", r3, 1'b0);
    repeat (5) step();
    check("t3_no_overrun_yet", ov3, 1'b0);
    check("t3_last_scan", r3, 1'b0);
    step();
    check("t3_idle_gap", r3, 1'b1);
    check("t3_overrun", ov3, 1'b1);
    check("t3_first_scan", s3, 24'hFFFEFE);
    step();
    check("t3_rescan", r3, 1'b0);
    repeat (100) step();
    check("t3_overrun_sticky", ov3, 1'b1);
    check("t3_err", err3, 1'b0);
    #1 rst3_n = 1'b0;
    #1;
    check("t3_overrun_reset", ov3, 1'b0);
    check("t3_reset_ready", r3, 1'b1);
    step();
    rst3_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pet_stat_bank.md
Name: pet_stat_bank

Overview:
- Parametrised successor to the fixed six-stat pet attribute logic.
- Holds NUM_STATS saturating counters of STAT_W bits each, with its own tick prescaler.
- On each tick, a scan FSM applies random-gated decay, one stat per cycle.
- Accepts ADD/SUB/SET commands over a valid/ready handshake and emits per-stat low flags plus an aggregate mood code for the status/display logic.

Parameters:
- NUM_STATS, 6, number of stat channels (1..16)
- STAT_W, 4, bits per stat
- TICK_DIV, 10_000_000, clk cycles per decay tick (>=2)
- INIT_VAL, 4'hF, reset value of every stat, truncated to STAT_W
- LOW_THR, 4, a stat strictly below this raises its low flag
- IDX_W, 4, command index width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rand_in  in  8  random byte from the LFSR block
- cmd_valid  in  1  command present
- cmd_ready  out  1  bank can accept a command
- cmd_op  in  2  00 ADD, 01 SUB, 10 SET, 11 NOP
- cmd_idx  in  IDX_W  target stat
- cmd_val  in  STAT_W  operand
- cmd_err  out  1  one-cycle pulse: accepted command had cmd_idx >= NUM_STATS
- stats_flat  out  NUM_STATS*STAT_W  stat i at bits [i*STAT_W +: STAT_W]
- low_flags  out  NUM_STATS  bit i = (stat i < LOW_THR)
- mood  out  2  00 HAPPY, 01 OK, 10 SAD, 11 CRITICAL
- tick  out  1  one-cycle pulse at each prescaler wrap
- overrun  out  1  sticky: a tick was lost

Behaviour:
- Reset (async, rst_n=0):
  - all stats = INIT_VAL; prescaler = 0; FSM = IDLE
  - tick, cmd_err, overrun, pending = 0; cmd_ready = 1
- Prescaler:
  - counts 0..TICK_DIV-1 and wraps.
  - tick is high in the cycle the counter equals TICK_DIV-1.
- FSM IDLE:
  - cmd_ready = 1.
  - Handshake completes on cmd_valid & cmd_ready; the update lands at that edge and is visible on stats_flat the next cycle.
  - ADD: min(stat + val, 2^STAT_W - 1).
  - SUB: max(stat - val, 0).
  - SET: stat = val.
  - NOP: accepted, no effect.
  - Out-of-range cmd_idx: accepted, no stat change, cmd_err pulses one cycle.
  - tick (or pending set): latch rand_in into rsnap, clear pending, go to SCAN with idx = 0.
  - A command is still accepted in the tick cycle itself; the command update applies first and the scan sees the result.
- FSM SCAN:
  - cmd_ready = 0.
  - Each cycle, if rsnap[idx % 8] = 1, stat[idx] decrements by one, saturating at 0.
  - idx increments; after idx = NUM_STATS-1, return to IDLE.
  - Scan length is exactly NUM_STATS cycles.
- Tick during SCAN: set pending. A further tick while pending is already 1 sets overrun; that tick is dropped and the counter keeps running.
- Outputs low_flags and mood are registered from current stats, with one cycle latency after a stat change.
- mood, by number of set low_flags:
  - 0 -> HAPPY
  - 1..2 -> OK
  - >=3 -> SAD
  - all stats == 0 -> CRITICAL, overriding the above
- overrun clears only on reset.

Optional Feature:
- Macro PET_DEATH_EN.
- Defined:
  - A counter counts ticks while all stats == 0 and resets to 0 when any stat is nonzero.
  - On reaching 8, a dead flag latches.
  - While dead: cmd_ready stays 0, decay stops, mood = CRITICAL; cleared only by reset.
- Undefined: no counter or dead flag; behaviour as above.

Decomposition:
- Package pet_pkg holds:
  - the opcode constants OP_ADD/OP_SUB/OP_SET/OP_NOP
  - the mood constants MOOD_HAPPY/OK/SAD/CRITICAL
  - the FSM state enum ST_IDLE/ST_SCAN
- One sub-module, pet_tick_gen: the prescaler producing tick, parametrised by TICK_DIV.

Test Plan:
- Reset with defaults -> every stat = 4'hF, mood = HAPPY, low_flags = 0, cmd_ready = 1, overrun = 0.
- TICK_DIV = 4, rand_in = 8'h05 held:
  - each tick decrements stats 0 and 2 only; cmd_ready is low for exactly 6 cycles after each tick.
  - after 16 ticks, stats 0 and 2 = 0 and stay 0 (saturate), mood = OK.
- SET idx 1 to 4'hE, then ADD 5 -> stat1 = 4'hF (saturates); SUB 4'h9 from 3 -> 0; cmd_idx = 7 -> cmd_err pulse, stats unchanged.
- NUM_STATS = 6, TICK_DIV = 3:
  - a tick during SCAN sets pending and a back-to-back rescan follows.
  - a third tick while pending sets overrun = 1, sticky until rst_n low.
- SET all stats to 0 -> mood = CRITICAL next cycle. With PET_DEATH_EN, after 8 ticks cmd_ready stays 0 and ADD is ignored; without PET_DEATH_EN, ADD still works.
- Assert rst_n low mid-SCAN -> stats return to INIT_VAL asynchronously and the FSM is IDLE on release.
